// File: rtl/ltc2992_cfg_seq.sv
// ltc2992_cfg_seq: transaction sequencer in front of the I2C byte-write engine.
// After reset it writes a four-entry register table to the LTC2992, one
// transaction at a time, retrying any transaction that times out. Once the
// table is done it serves single register writes from system logic.
//
// Handshakes:
//   - Engine: O_send_en high starts a transaction. The engine answers with a
//     one-cycle I_done_flag, which is sampled only in ISSUE. O_send_en then
//     drops for at least one cycle, which returns the engine to INIT.
//   - User: I_wr_req is a single-cycle request, sampled only in READY; it
//     carries I_wr_addr/I_wr_data. O_wr_busy is high from the cycle after
//     acceptance until completion. Completion is a one-cycle O_wr_ack
//     (success) or O_wr_err (retries exhausted), coincident with O_wr_busy
//     falling. A request while busy is dropped and never queued.
//
// dbg_state exposes the FSM state (0 GAP, 1 ISSUE, 2 RELEASE, 3 NEXT,
// 4 READY).
module ltc2992_cfg_seq #(
    parameter logic [6:0]  P_DEV_ADDR  = 7'h6F,
    parameter logic [15:0] P_REG0      = 16'h0000,
    parameter logic [15:0] P_REG1      = 16'h0118,
    parameter logic [15:0] P_REG2      = 16'h0200,
    parameter logic [15:0] P_REG3      = 16'h0300,
    parameter int          P_GAP       = 100,
    parameter int          P_TIMEOUT   = 20000,
    parameter int          P_MAX_RETRY = 3
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_done_flag,
    output logic       O_send_en,
    output logic [6:0] O_dev_addr,
    output logic [7:0] O_word_addr,
    output logic [7:0] O_write_date,
    output logic [1:0] O_BYTE,
    input  logic       I_restart,
    input  logic       I_wr_req,
    input  logic [7:0] I_wr_addr,
    input  logic [7:0] I_wr_data,
    output logic       O_wr_busy,
    output logic       O_wr_ack,
    output logic       O_wr_err,
    output logic       O_cfg_done,
    output logic       O_cfg_err,
    output logic [2:0] dbg_state
);

    // Counters are sized to hold their full terminal value without wrapping.
    localparam int GW = $clog2(P_GAP + 1);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam int RW = $clog2(P_MAX_RETRY + 2);

    localparam logic [GW-1:0] GAP_LAST  = GW'(P_GAP - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(P_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(P_MAX_RETRY);

    typedef enum logic [2:0] {
        S_GAP     = 3'd0,
        S_ISSUE   = 3'd1,
        S_RELEASE = 3'd2,
        S_NEXT    = 3'd3,
        S_READY   = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [RW-1:0] retry;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          user_mode;  // current transaction is a user write
    logic          ok;         // outcome of the last ISSUE window

    function automatic logic [15:0] entry_word(input logic [1:0] i);
        case (i)
            2'd0:    return P_REG0;
            2'd1:    return P_REG1;
            2'd2:    return P_REG2;
            default: return P_REG3;
        endcase
    endfunction

    assign O_dev_addr = P_DEV_ADDR;
    assign O_BYTE     = 2'd1;
    assign dbg_state  = state;

    // Sequencer FSM: gap, issue with timeout, release, advance/retry, ready.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state        <= S_GAP;
            idx          <= 2'd0;
            retry        <= '0;
            gap_cnt      <= '0;
            tmo_cnt      <= '0;
            user_mode    <= 1'b0;
            ok           <= 1'b0;
            O_send_en    <= 1'b0;
            O_word_addr  <= P_REG0[15:8];
            O_write_date <= P_REG0[7:0];
            O_wr_busy    <= 1'b0;
            O_wr_ack     <= 1'b0;
            O_wr_err     <= 1'b0;
            O_cfg_done   <= 1'b0;
            O_cfg_err    <= 1'b0;
        end else begin
            O_wr_ack <= 1'b0;
            O_wr_err <= 1'b0;
            case (state)
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        tmo_cnt   <= '0;
                        O_send_en <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (I_done_flag) begin
                        ok        <= 1'b1;
                        O_send_en <= 1'b0;
                        state     <= S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        ok        <= 1'b0;
                        O_send_en <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (ok) begin
                        state <= S_NEXT;
                    end else if (retry < RETRY_MAX) begin
                        retry <= retry + 1'b1;
                        state <= S_GAP;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    retry <= '0;
                    if (user_mode) begin
                        O_wr_ack  <= ok;
                        O_wr_err  <= ~ok;
                        O_wr_busy <= 1'b0;
                        user_mode <= 1'b0;
                        state     <= S_READY;
                    end else begin
                        if (!ok) O_cfg_err <= 1'b1;
                        if (idx == 2'd3) begin
                            O_cfg_done <= 1'b1;
                            state      <= S_READY;
                        end else begin
                            idx                         <= idx + 2'd1;
                            {O_word_addr, O_write_date} <= entry_word(idx + 2'd1);
                            state                       <= S_GAP;
                        end
                    end
                end
                S_READY: begin
                    // Restart takes priority; a simultaneous request is dropped.
                    if (I_restart) begin
                        O_cfg_done                  <= 1'b0;
                        O_cfg_err                   <= 1'b0;
                        idx                         <= 2'd0;
                        {O_word_addr, O_write_date} <= entry_word(2'd0);
                        user_mode                   <= 1'b0;
                        state                       <= S_GAP;
                    end else if (I_wr_req) begin
                        O_word_addr  <= I_wr_addr;
                        O_write_date <= I_wr_data;
                        O_wr_busy    <= 1'b1;
                        user_mode    <= 1'b1;
                        state        <= S_GAP;
                    end
                end
                default: state <= S_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2992_cfg_seq.sv
// tb_ltc2992_cfg_seq: directed bench for ltc2992_cfg_seq with a simple
// engine model that answers with done a fixed latency after enable, or never
// for a chosen register address.
module tb_ltc2992_cfg_seq;

  localparam int GAP   = 8;
  localparam int TMO   = 30;
  localparam int MAXR  = 3;
  localparam int LAT   = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       done_flag, send_en, restart, wr_req;
  logic [6:0] dev_addr;
  logic [7:0] word_addr, write_date, wr_addr, wr_data;
  logic [1:0] byte_cnt;
  logic       wr_busy, wr_ack, wr_err, cfg_done, cfg_err;
  logic [2:0] dbg_state;

  ltc2992_cfg_seq #(
    .P_GAP(GAP), .P_TIMEOUT(TMO), .P_MAX_RETRY(MAXR)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_done_flag(done_flag),
    .O_send_en(send_en), .O_dev_addr(dev_addr), .O_word_addr(word_addr),
    .O_write_date(write_date), .O_BYTE(byte_cnt), .I_restart(restart),
    .I_wr_req(wr_req), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
    .O_wr_busy(wr_busy), .O_wr_ack(wr_ack), .O_wr_err(wr_err),
    .O_cfg_done(cfg_done), .O_cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- engine model ----------------
  int         eng_cnt;
  int         eng_lat = LAT;
  logic       eng_done;
  logic       hang_en = 1'b0;
  logic [7:0] hang_addr = 8'h00;
  logic       tb_done = 1'b0;
  assign done_flag = eng_done | tb_done;

  always @(posedge clk) begin
    if (rst || !send_en) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_cnt  <= eng_cnt + 1;
      eng_done <= !(hang_en && word_addr == hang_addr) && (eng_cnt == eng_lat - 1);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction monitor: logs each O_send_en window and checks its tag.
  int          txn_cnt = 0;
  int          low_q[$];
  int          high_q[$];
  int          low_run = 0;
  int          high_run = 0;
  int          stable_err = 0;
  logic        prev_en = 1'b0;
  logic [15:0] cur_tag = 16'h0;
  logic [15:0] exp_tag;

  always @(negedge clk) begin
    if (rst) begin
      prev_en  = 1'b0;
      low_run  = 0;
      high_run = 0;
    end else begin
      if (send_en && !prev_en) begin
        cur_tag = {word_addr, write_date};
        txn_cnt++;
        low_q.push_back(low_run);
        low_run  = 0;
        high_run = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_txn: got 0x%0h expected none at %0t", cur_tag, $time);
        end else begin
          exp_tag = exp_q.pop_front();
          check("txn_tag", 32'(cur_tag), 32'(exp_tag));
        end
      end
      if (send_en) begin
        high_run++;
        if ({word_addr, write_date} !== cur_tag) stable_err++;
      end else begin
        if (prev_en) high_q.push_back(high_run);
        low_run++;
      end
      prev_en = send_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    low_q.delete();
    high_q.delete();
    txn_cnt = 0;
  endtask

  task automatic push_table();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0118);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0300);
  endtask

  task automatic wait_cfg_done(input string name, input int budget);
    int n;
    n = 0;
    while (cfg_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(cfg_done), 32'd1);
  endtask

  task automatic pulse_restart(input logic with_req);
    restart = 1'b1;
    wr_req  = with_req;
    wr_addr = 8'h77;
    wr_data = 8'h66;
    @(negedge clk);
    restart = 1'b0;
    wr_req  = 1'b0;
  endtask

  // ---------------- user write vectors ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       hang;
    int         exp_ack;
    int         exp_err;
    int         exp_txn;
  } wr_vec_t;

  wr_vec_t vecs[4];

  initial begin
    int ack_cnt, err_cnt, n, busy_seen_low;
    restart = 1'b0;
    wr_req  = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;

    vecs[0] = '{addr: 8'h0A, data: 8'h5C, hang: 1'b0, exp_ack: 1, exp_err: 0, exp_txn: 1};
    vecs[1] = '{addr: 8'hFF, data: 8'h00, hang: 1'b0, exp_ack: 1, exp_err: 0, exp_txn: 1};
    vecs[2] = '{addr: 8'h12, data: 8'h34, hang: 1'b1, exp_ack: 0, exp_err: 1, exp_txn: MAXR + 1};
    vecs[3] = '{addr: 8'h00, data: 8'hA5, hang: 1'b0, exp_ack: 1, exp_err: 0, exp_txn: 1};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_word", 32'(word_addr), 32'h00);
    check("rst_data", 32'(write_date), 32'h00);
    check("rst_flags", 32'({wr_busy, wr_ack, wr_err, cfg_done, cfg_err}), 32'd0);
    check("rst_dev_addr", 32'(dev_addr), 32'h6F);
    check("rst_byte", 32'(byte_cnt), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // ---- table after reset ----
    clear_logs();
    push_table();
    rst = 1'b0;
    wait_cfg_done("table", 2000);
    check("table_txn_cnt", 32'(txn_cnt), 32'd4);
    check("table_err", 32'(cfg_err), 32'd0);
    check("table_first_low", 32'(low_q[0]), 32'(GAP));
    for (int i = 1; i < 4; i++) check("table_low", 32'(low_q[i]), 32'(GAP + 2));
    for (int i = 0; i < 4; i++) check("table_high", 32'(high_q[i]), 32'(LAT + 1));
    check("table_state_ready", 32'(dbg_state), 32'd4);

    // ---- user writes from the vector table ----
    for (int v = 0; v < 4; v++) begin
      // A stray done in READY must be ignored.
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      @(negedge clk);
      check("stray_done_state", 32'(dbg_state), 32'd4);
      check("stray_done_en", 32'(send_en), 32'd0);

      clear_logs();
      for (int k = 0; k < vecs[v].exp_txn; k++) exp_q.push_back({vecs[v].addr, vecs[v].data});
      hang_en   = vecs[v].hang;
      hang_addr = vecs[v].addr;
      wr_addr   = vecs[v].addr;
      wr_data   = vecs[v].data;
      wr_req    = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      check("wr_busy_set", 32'(wr_busy), 32'd1);
      check("wr_capture", 32'({word_addr, write_date}), 32'({vecs[v].addr, vecs[v].data}));
      repeat (3) @(negedge clk);
      // Request while busy: must be dropped.
      wr_addr = 8'hEE;
      wr_data = 8'hEE;
      wr_req  = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;

      ack_cnt = 0;
      err_cnt = 0;
      busy_seen_low = 0;
      n = 0;
      while (n < 1000 && !(busy_seen_low != 0 && n > 200)) begin
        @(negedge clk);
        n++;
        if (wr_ack || wr_err) check("ack_with_busy_low", 32'(wr_busy), 32'd0);
        if (wr_ack) ack_cnt++;
        if (wr_err) err_cnt++;
        if (!wr_busy) busy_seen_low = 1;
      end
      check("wr_done_in_budget", 32'(busy_seen_low), 32'd1);
      check("wr_ack_cnt", 32'(ack_cnt), 32'(vecs[v].exp_ack));
      check("wr_err_cnt", 32'(err_cnt), 32'(vecs[v].exp_err));
      check("wr_txn_cnt", 32'(txn_cnt), 32'(vecs[v].exp_txn));
      if (vecs[v].hang) begin
        for (int k = 0; k < MAXR + 1; k++) check("wr_timeout_win", 32'(high_q[k]), 32'(TMO));
      end
      check("wr_cfg_done_kept", 32'(cfg_done), 32'd1);
      hang_en = 1'b0;
    end

    // ---- entry 1 never answers: retries then cfg_err ----
    clear_logs();
    exp_q.push_back(16'h0000);
    for (int k = 0; k < MAXR + 1; k++) exp_q.push_back(16'h0118);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0300);
    hang_en   = 1'b1;
    hang_addr = 8'h01;
    pulse_restart(1'b0);
    check("retry_done_cleared", 32'(cfg_done), 32'd0);
    wait_cfg_done("retry", 3000);
    hang_en = 1'b0;
    check("retry_txn_cnt", 32'(txn_cnt), 32'(MAXR + 4));
    check("retry_cfg_err", 32'(cfg_err), 32'd1);
    check("retry_low_first", 32'(low_q[1]), 32'(GAP + 2));
    for (int k = 2; k < MAXR + 2; k++) check("retry_low", 32'(low_q[k]), 32'(GAP + 1));
    for (int k = 1; k < MAXR + 2; k++) check("retry_win", 32'(high_q[k]), 32'(TMO));
    check("retry_entry2_high", 32'(high_q[MAXR + 2]), 32'(LAT + 1));

    // ---- done in the same cycle as timeout: success, no retry ----
    clear_logs();
    push_table();
    eng_lat = TMO - 1;
    pulse_restart(1'b0);
    check("tie_err_cleared", 32'(cfg_err), 32'd0);
    wait_cfg_done("tie", 3000);
    check("tie_txn_cnt", 32'(txn_cnt), 32'd4);
    check("tie_cfg_err", 32'(cfg_err), 32'd0);
    for (int k = 0; k < 4; k++) check("tie_win", 32'(high_q[k]), 32'(TMO));
    for (int k = 1; k < 4; k++) check("tie_low", 32'(low_q[k]), 32'(GAP + 2));
    eng_lat = LAT;

    // ---- restart and request together: restart wins ----
    clear_logs();
    push_table();
    pulse_restart(1'b1);
    check("both_done_cleared", 32'(cfg_done), 32'd0);
    check("both_busy", 32'(wr_busy), 32'd0);
    check("both_word", 32'(word_addr), 32'h00);
    n = 0;
    busy_seen_low = 0;
    while (cfg_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (wr_busy || wr_ack) busy_seen_low++;
    end
    check("both_cfg_done", 32'(cfg_done), 32'd1);
    check("both_no_user", 32'(busy_seen_low), 32'd0);
    check("both_txn_cnt", 32'(txn_cnt), 32'd4);

    // ---- reset in the middle of entry 2's ISSUE ----
    clear_logs();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0118);
    exp_q.push_back(16'h0200);
    pulse_restart(1'b0);
    n = 0;
    while (!(send_en === 1'b1 && word_addr == 8'h02) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_entry2", 32'(send_en && word_addr == 8'h02), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_send_en", 32'(send_en), 32'd0);
    check("mid_word_data", 32'({word_addr, write_date}), 32'h0000);
    check("mid_flags", 32'({wr_busy, wr_ack, wr_err, cfg_done, cfg_err}), 32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    check("mid_exp_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    clear_logs();
    push_table();
    rst = 1'b0;
    wait_cfg_done("mid", 2000);
    check("mid_txn_cnt", 32'(txn_cnt), 32'd4);
    check("mid_first_low", 32'(low_q[0]), 32'(GAP));
    check("mid_cfg_err", 32'(cfg_err), 32'd0);

    // ---- final report ----
    check("addr_data_stable", 32'(stable_err), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ltc2992_cfg_seq.md
# ltc2992_cfg_seq

Transaction sequencer directly upstream of the I2C byte-write engine. After reset it writes a four-entry register table to the LTC2992 one transaction at a time. It drives the engine's enable, address and data inputs, consumes its one-cycle done pulse, and retries a transaction that times out; the engine never signals failure, it only restarts silently on NACK. Once the table completes, it accepts single register writes from system logic through a request/ack handshake.

## Interface

Parameters:
- P_DEV_ADDR, 7'h6F: 7-bit LTC2992 slave address.
- P_REG0, 16'h0000: table entry 0 as {word_addr, data}.
- P_REG1, 16'h0118: table entry 1.
- P_REG2, 16'h0200: table entry 2.
- P_REG3, 16'h0300: table entry 3.
- P_GAP, 100: idle cycles with O_send_en low before each transaction, ≥2.
- P_TIMEOUT, 20000: maximum cycles in ISSUE before a timeout.
- P_MAX_RETRY, 3: retries per transaction after the first attempt.

Ports:
- I_clk, in, 1: system clock, the same clock as the engine.
- I_rst, in, 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- I_done_flag, in, 1: engine done pulse, one cycle wide.
- O_send_en, out, 1: engine enable. Low holds the engine in INIT.
- O_dev_addr, out, 7: always P_DEV_ADDR.
- O_word_addr, out, 8: register address of the current transaction.
- O_write_date, out, 8: data byte of the current transaction.
- O_BYTE, out, 2: constant 2'd1.
- I_restart, in, 1: rerun the table. Honoured only in READY with O_wr_busy low.
- I_wr_req, in, 1: request a user write. Sampled only in READY.
- I_wr_addr, in, 8: user register address, captured with I_wr_req.
- I_wr_data, in, 8: user data, captured with I_wr_req.
- O_wr_busy, out, 1: user write in progress.
- O_wr_ack, out, 1: one-cycle pulse when a user write succeeds.
- O_wr_err, out, 1: one-cycle pulse when a user write exhausts its retries.
- O_cfg_done, out, 1: table finished. Sticky until restart.
- O_cfg_err, out, 1: at least one table entry failed. Sticky until restart.

## Operation

- States: GAP, ISSUE, RELEASE, NEXT, READY.
- Reset values: state GAP, entry index 0, retry count 0, all counters 0, O_send_en 0. O_word_addr and O_write_date reset to entry 0. O_wr_busy, O_wr_ack, O_wr_err, O_cfg_done and O_cfg_err all reset to 0.
- GAP: O_send_en=0. Counts P_GAP cycles, then goes to ISSUE.
- ISSUE: O_send_en=1. The word_addr and data outputs stay stable for the whole state, and the timeout counter increments each cycle.
  - I_done_flag high: go to RELEASE with success.
  - Counter reaches P_TIMEOUT-1 without done: go to RELEASE with failure.
  - Done and timeout in the same cycle: done wins.
- RELEASE: O_send_en=0 for one cycle, which forces the engine back to INIT.
  - Success: go to NEXT.
  - Failure with retry count < P_MAX_RETRY: increment the retry count and return to GAP on the same entry.
  - Failure with retries exhausted: go to NEXT with failure.
- NEXT: clears the retry count.
  - Table mode, entry failed: set O_cfg_err and advance anyway.
  - Table mode, index < 3: increment the index, load the next entry and go to GAP.
  - Table mode, index = 3: set O_cfg_done and go to READY.
  - User mode: pulse O_wr_ack on success or O_wr_err on failure, clear O_wr_busy, and go to READY.
- READY: O_send_en=0.
  - I_wr_req=1: capture addr and data onto the outputs, set O_wr_busy and go to GAP in user mode.
  - I_restart=1: clear O_cfg_done and O_cfg_err, set index to 0 and go to GAP in table mode.
  - I_wr_req and I_restart in the same cycle: I_restart wins and the request is dropped.
- I_wr_req outside READY is ignored and not queued. I_restart outside READY is ignored.
- I_done_flag outside ISSUE is ignored.
- I_rst mid-transaction: all state returns to reset values on the next edge. O_send_en drops in that same edge, which aborts the engine.

## Timing

- O_send_en falls on the edge after the cycle in which I_done_flag is sampled high. The engine may reach LOAD1 for one cycle before it is forced to INIT; no bus activity occurs.
- Minimum low time of O_send_en between transactions is P_GAP+1 cycles.
- A successful transaction costs P_GAP + (engine latency) + 2 cycles of sequencer overhead.
- The first O_send_en rise occurs P_GAP cycles after I_rst deasserts.
- O_wr_ack or O_wr_err is asserted in the same cycle O_wr_busy falls. A new I_wr_req is accepted from the following cycle.
- The timeout counter and retry counter are sized to hold P_TIMEOUT and P_MAX_RETRY with no wrap.

## Test plan

- Reset release with an engine model that pulses done 500 cycles after enable. Required: four transactions in order with addr/data 00/00, 01/18, 02/00, 03/00, each preceded by 100 low cycles. O_cfg_done rises after the fourth; O_cfg_err stays 0.
- Engine model never pulses done on entry 1. Required: four ISSUE windows of exactly 20000 cycles each on 01/18. Then O_cfg_err=1, entry 2 proceeds, and O_cfg_done=1.
- Done and timeout in the same cycle. Required: treated as success and the retry count is unchanged.
- In READY, I_wr_req with addr 0x0A and data 0x5C. Required: O_wr_busy=1 and one transaction with 0A/5C, followed by a single O_wr_ack pulse. A second I_wr_req issued while busy produces no transaction.
- I_rst asserted in the middle of the ISSUE state of entry 2. Required: O_send_en=0 on the next edge, all outputs return to reset values, and the sequence restarts from entry 0.
- I_restart and I_wr_req together in READY. Required: the table is rerun, no user write occurs, and O_cfg_done clears then reasserts.
